// File: rtl/buffered_matrixn_grayscale_window.sv
// Grayscale NxN sliding-window builder with P_WINDOW_SIZE-1 line buffers.
// Define BUFFERED_MATRIXN_BT601_EN for BT.601 luma weights instead of (R+2G+B)/4.
module buffered_matrixn_grayscale_window #(
  parameter int unsigned P_FRAME_COLUMNS     = 640,
  parameter int unsigned P_FRAME_ROWS        = 480,
  parameter int unsigned P_PIXEL_DEPTH       = 24,
  parameter int unsigned P_WINDOW_SIZE       = 3,
  parameter int unsigned P_FRAME_COLUMN_BITS = $clog2(P_FRAME_COLUMNS),
  parameter int unsigned P_FRAME_ROW_BITS    = $clog2(P_FRAME_ROWS),
  parameter int unsigned P_SUBPIXEL_DEPTH    = P_PIXEL_DEPTH / 3,
  parameter int unsigned P_WINDOW_BITS       = P_SUBPIXEL_DEPTH * P_WINDOW_SIZE * P_WINDOW_SIZE
) (
  input  logic                           I_CLK,
  input  logic                           I_RESET,
  input  logic                           I_PIXEL_VALID,
  input  logic                           I_FRAME_START,
  input  logic [P_PIXEL_DEPTH-1:0]       I_PIXEL,
  output logic [P_FRAME_COLUMN_BITS-1:0] O_PIXEL_COLUMN,
  output logic [P_FRAME_ROW_BITS-1:0]    O_PIXEL_ROW,
  output logic [P_WINDOW_BITS-1:0]       O_PIXEL_WINDOW,
  output logic                           O_WINDOW_VALID,
  output logic                           O_FRAME_DONE
);

  localparam int unsigned S  = P_SUBPIXEL_DEPTH;
  localparam int unsigned N  = P_WINDOW_SIZE;
  localparam int unsigned H  = (N - 1) / 2;
  localparam int unsigned NL = N - 1;
  localparam int unsigned CB = P_FRAME_COLUMN_BITS;
  localparam int unsigned RB = P_FRAME_ROW_BITS;
  localparam int unsigned WB = P_WINDOW_BITS;
`ifdef BUFFERED_MATRIXN_BT601_EN
  localparam int unsigned GW = S + 8;
`else
  localparam int unsigned GW = S + 2;
`endif

  localparam logic [CB-1:0] LAST_COL = CB'(P_FRAME_COLUMNS - 1);
  localparam logic [RB-1:0] LAST_ROW = RB'(P_FRAME_ROWS - 1);
  localparam logic [CB-1:0] MIN_COL  = CB'(2 * H);
  localparam logic [RB-1:0] MIN_ROW  = RB'(2 * H);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DONE} state_t;

  state_t          state_q, state_d;
  logic [CB-1:0]   col_q, col_d;
  logic [RB-1:0]   row_q, row_d;
  logic            accept_c;
  logic [CB-1:0]   pix_col_c;
  logic [RB-1:0]   pix_row_c;

  logic [S-1:0]    red_c, green_c, blue_c;
  logic [GW-1:0]   gray_sum_c;
  logic [S-1:0]    gray_c;

  logic            s1_valid_q, s1_valid_d;
  logic [S-1:0]    s1_gray_q, s1_gray_d;
  logic [CB-1:0]   s1_col_q, s1_col_d;
  logic [RB-1:0]   s1_row_q, s1_row_d;

  logic [S-1:0]    line_mem_q [NL][P_FRAME_COLUMNS];
  logic [S-1:0]    col_vec_c [N];

  logic [WB-1:0]   win_q, win_d;
  logic            s2_valid_q, s2_valid_d;
  logic            s2_done_q, s2_done_d;
  logic [CB-1:0]   s2_col_q, s2_col_d;
  logic [RB-1:0]   s2_row_q, s2_row_d;

  logic            out_valid_q, out_valid_d;
  logic            out_done_q, out_done_d;
  logic [CB-1:0]   out_col_q, out_col_d;
  logic [RB-1:0]   out_row_q, out_row_d;
  logic [WB-1:0]   out_win_q, out_win_d;

  // Frame FSM and input raster counters; a frame start always re-anchors at (0,0).
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    accept_c  = 1'b0;
    pix_col_c = col_q;
    pix_row_c = row_q;
    if (I_PIXEL_VALID && I_FRAME_START) begin
      accept_c  = 1'b1;
      pix_col_c = '0;
      pix_row_c = '0;
    end else if (I_PIXEL_VALID && (state_q == ST_ACTIVE)) begin
      accept_c = 1'b1;
    end
    if (accept_c) begin
      state_d = ST_ACTIVE;
      if (pix_col_c == LAST_COL) begin
        col_d = '0;
        if (pix_row_c == LAST_ROW) begin
          row_d   = '0;
          state_d = ST_DONE;
        end else begin
          row_d = pix_row_c + RB'(1);
        end
      end else begin
        col_d = pix_col_c + CB'(1);
        row_d = pix_row_c;
      end
    end
  end

  // Grayscale conversion, wide enough that the weighted sum never overflows.
  always_comb begin
    red_c   = I_PIXEL[3*S-1 -: S];
    green_c = I_PIXEL[2*S-1 -: S];
    blue_c  = I_PIXEL[S-1 -: S];
`ifdef BUFFERED_MATRIXN_BT601_EN
    gray_sum_c = GW'(red_c) * GW'(77) + GW'(green_c) * GW'(150) + GW'(blue_c) * GW'(29);
    gray_c     = gray_sum_c[GW-1 -: S];
`else
    gray_sum_c = GW'(red_c) + (GW'(green_c) << 1) + GW'(blue_c);
    gray_c     = gray_sum_c[GW-1 -: S];
`endif
  end

  always_comb begin
    s1_valid_d = accept_c;
    s1_gray_d  = accept_c ? gray_c    : s1_gray_q;
    s1_col_d   = accept_c ? pix_col_c : s1_col_q;
    s1_row_d   = accept_c ? pix_row_c : s1_row_q;
  end

  // Column vector: oldest buffered line on top, the fresh pixel at the bottom.
  always_comb begin
    for (int unsigned r = 0; r < NL; r++) begin
      col_vec_c[r] = line_mem_q[NL-1-r][s1_col_q];
    end
    col_vec_c[N-1] = s1_gray_q;
  end

  // Window shifts left one column per accepted pixel; new column enters at the right.
  always_comb begin
    win_d      = win_q;
    s2_valid_d = 1'b0;
    s2_done_d  = 1'b0;
    s2_col_d   = s2_col_q;
    s2_row_d   = s2_row_q;
    if (s1_valid_q) begin
      for (int unsigned r = 0; r < N; r++) begin
        win_d[(N-1-r)*N*S + S +: (N-1)*S] = win_q[(N-1-r)*N*S +: (N-1)*S];
        win_d[(N-1-r)*N*S +: S]           = col_vec_c[r];
      end
      s2_valid_d = (s1_row_q >= MIN_ROW) && (s1_col_q >= MIN_COL);
      s2_done_d  = s2_valid_d && (s1_row_q == LAST_ROW) && (s1_col_q == LAST_COL);
      s2_col_d   = s1_col_q - CB'(H);
      s2_row_d   = s1_row_q - RB'(H);
    end
  end

  always_comb begin
    out_valid_d = s2_valid_q;
    out_done_d  = s2_done_q;
    out_col_d   = out_col_q;
    out_row_d   = out_row_q;
    out_win_d   = out_win_q;
    if (s2_valid_q) begin
      out_col_d = s2_col_q;
      out_row_d = s2_row_q;
      out_win_d = win_q;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_gray_q   <= '0;
      s1_col_q    <= '0;
      s1_row_q    <= '0;
      win_q       <= '0;
      s2_valid_q  <= 1'b0;
      s2_done_q   <= 1'b0;
      s2_col_q    <= '0;
      s2_row_q    <= '0;
      out_valid_q <= 1'b0;
      out_done_q  <= 1'b0;
      out_col_q   <= '0;
      out_row_q   <= '0;
      out_win_q   <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      s1_valid_q  <= s1_valid_d;
      s1_gray_q   <= s1_gray_d;
      s1_col_q    <= s1_col_d;
      s1_row_q    <= s1_row_d;
      win_q       <= win_d;
      s2_valid_q  <= s2_valid_d;
      s2_done_q   <= s2_done_d;
      s2_col_q    <= s2_col_d;
      s2_row_q    <= s2_row_d;
      out_valid_q <= out_valid_d;
      out_done_q  <= out_done_d;
      out_col_q   <= out_col_d;
      out_row_q   <= out_row_d;
      out_win_q   <= out_win_d;
    end
  end

  // Line buffers cascade: each accepted pixel pushes its column down one line.
  always_ff @(posedge I_CLK) begin
    if (s1_valid_q) begin
      line_mem_q[0][s1_col_q] <= s1_gray_q;
      for (int unsigned k = 1; k < NL; k++) begin
        line_mem_q[k][s1_col_q] <= line_mem_q[k-1][s1_col_q];
      end
    end
  end

  assign O_PIXEL_COLUMN = out_col_q;
  assign O_PIXEL_ROW    = out_row_q;
  assign O_PIXEL_WINDOW = out_win_q;
  assign O_WINDOW_VALID = out_valid_q;
  assign O_FRAME_DONE   = out_done_q;

endmodule

// File: tb/tb_buffered_matrixn_grayscale_window.sv
// Scoreboard bench: 3x3 and 5x5 instances share one 8x6 pixel stream.
module tb_buffered_matrixn_grayscale_window;

  localparam int COLS = 8;
  localparam int ROWS = 6;

  typedef struct {
    int           row;
    int           col;
    logic [199:0] win;
    bit           done;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pv  = 1'b0;
  logic         pf  = 1'b0;
  logic [23:0]  pix = '0;

  logic [2:0]   col3, row3, col5, row5;
  logic [71:0]  win3;
  logic [199:0] win5;
  logic         val3, done3, val5, done5;

  int     cyc = 0;
  int     nchecks = 0;
  int     nerrors = 0;
  exp_t   q3[$];
  exp_t   q5[$];
  logic [7:0] img [ROWS][COLS];
  bit     m_active = 1'b0;
  int     m_row = 0;
  int     m_col = 0;

  int           wcnt3 = 0, wcnt5 = 0;
  logic [71:0]  first3;
  int           first_r5, first_c5, last_r3, last_c3, last_r5, last_c5;

  buffered_matrixn_grayscale_window #(
    .P_FRAME_COLUMNS(COLS), .P_FRAME_ROWS(ROWS), .P_PIXEL_DEPTH(24), .P_WINDOW_SIZE(3)
  ) u_dut3 (
    .I_CLK(clk), .I_RESET(rst), .I_PIXEL_VALID(pv), .I_FRAME_START(pf), .I_PIXEL(pix),
    .O_PIXEL_COLUMN(col3), .O_PIXEL_ROW(row3), .O_PIXEL_WINDOW(win3),
    .O_WINDOW_VALID(val3), .O_FRAME_DONE(done3)
  );

  buffered_matrixn_grayscale_window #(
    .P_FRAME_COLUMNS(COLS), .P_FRAME_ROWS(ROWS), .P_PIXEL_DEPTH(24), .P_WINDOW_SIZE(5)
  ) u_dut5 (
    .I_CLK(clk), .I_RESET(rst), .I_PIXEL_VALID(pv), .I_FRAME_START(pf), .I_PIXEL(pix),
    .O_PIXEL_COLUMN(col5), .O_PIXEL_ROW(row5), .O_PIXEL_WINDOW(win5),
    .O_WINDOW_VALID(val5), .O_FRAME_DONE(done5)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gray_of(input logic [23:0] p);
    int s;
`ifdef BUFFERED_MATRIXN_BT601_EN
    s = (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) >> 8;
`else
    s = (int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0])) >> 2;
`endif
    return 8'(s);
  endfunction

  function automatic logic [199:0] mk_win(input int n, input int r, input int c);
    logic [199:0] w = '0;
    for (int dr = 0; dr < n; dr++)
      for (int dc = 0; dc < n; dc++)
        w = {w[191:0], img[r-n+1+dr][c-n+1+dc]};
    return w;
  endfunction

  task automatic push_exp(input int n, input int r, input int c);
    exp_t e;
    int h = (n - 1) / 2;
    if (r >= n - 1 && c >= n - 1) begin
      e.row  = r - h;
      e.col  = c - h;
      e.win  = mk_win(n, r, c);
      e.done = (r == ROWS - 1) && (c == COLS - 1);
      e.cyc  = cyc + 3;
      if (n == 3) q3.push_back(e);
      else        q5.push_back(e);
    end
  endtask

  // Drive one strobed pixel and let the reference frame model decide its fate.
  task automatic put(input logic [23:0] p, input bit fs);
    int r = 0, c = 0;
    bit acc = 1'b0;
    @(negedge clk);
    pv = 1'b1; pf = fs; pix = p;
    if (fs) begin
      acc = 1'b1;
    end else if (m_active) begin
      acc = 1'b1; r = m_row; c = m_col;
    end
    if (acc) begin
      img[r][c] = gray_of(p);
      push_exp(3, r, c);
      push_exp(5, r, c);
      m_active = 1'b1;
      if (c == COLS - 1) begin
        m_col = 0;
        if (r == ROWS - 1) begin m_row = 0; m_active = 1'b0; end
        else m_row = r + 1;
      end else begin
        m_col = c + 1; m_row = r;
      end
    end
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      pv = 1'b0; pf = 1'b0; pix = 24'($urandom);
    end
  endtask

  task automatic send_frame(input int base, input int maxgap, input int npix, input bit fs);
    logic [7:0] v;
    for (int i = 0; i < npix; i++) begin
      if (maxgap > 0) gap($urandom_range(0, maxgap));
      v = 8'(base + i);
      put({v, v, v}, fs && (i == 0));
    end
    gap(1);
  endtask

  task automatic send_const(input logic [23:0] p);
    for (int i = 0; i < ROWS * COLS; i++) put(p, i == 0);
    gap(1);
  endtask

  task automatic drain();
    int k = 0;
    while ((q3.size() != 0 || q5.size() != 0) && k < 40) begin
      @(negedge clk);
      k++;
    end
    gap(4);
    check_val("drain3", q3.size(), 0);
    check_val("drain5", q5.size(), 0);
  endtask

  task automatic clear_counts();
    wcnt3 = 0; wcnt5 = 0;
  endtask

  // Output monitor for the 3x3 instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (!val3) check_val("done3_alone", done3, 1'b0);
      if (val3) begin
        exp_t e;
        wcnt3++;
        if (wcnt3 == 1) first3 = win3;
        if (done3) begin last_r3 = row3; last_c3 = col3; end
        check_val("pending3", q3.size() > 0, 1'b1);
        if (q3.size() > 0) begin
          e = q3.pop_front();
          check_val("row3", row3, e.row);
          check_val("col3", col3, e.col);
          check_val("win3", win3, e.win);
          check_val("fdone3", done3, e.done);
          check_val("lat3", cyc, e.cyc);
        end
      end
    end
  end

  // Output monitor for the 5x5 instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (!val5) check_val("done5_alone", done5, 1'b0);
      if (val5) begin
        exp_t e;
        wcnt5++;
        if (wcnt5 == 1) begin first_r5 = row5; first_c5 = col5; end
        if (done5) begin last_r5 = row5; last_c5 = col5; end
        check_val("pending5", q5.size() > 0, 1'b1);
        if (q5.size() > 0) begin
          e = q5.pop_front();
          check_val("row5", row5, e.row);
          check_val("col5", col5, e.col);
          check_val("win5", win5, e.win);
          check_val("fdone5", done5, e.done);
          check_val("lat5", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  red_g;
    logic [71:0] red_win;

    // Reset with random valid pixels: outputs must stay zero.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pv = 1'b1; pf = 1'($urandom); pix = 24'($urandom);
      if (i > 0) begin
        check_val("rst_val3", val3, 1'b0);
        check_val("rst_done3", done3, 1'b0);
        check_val("rst_win3", win3, '0);
        check_val("rst_pos3", {row3, col3}, '0);
        check_val("rst_val5", val5, 1'b0);
        check_val("rst_win5", win5, '0);
      end
    end
    @(negedge clk);
    rst = 1'b0; pv = 1'b1; pf = 1'b0;
    // Pixels after reset but before any frame start are ignored.
    for (int i = 0; i < 12; i++) put(24'($urandom), 1'b0);
    gap(1);
    drain();
    check_val("no_frame_wins", wcnt3 + wcnt5, 0);

    // Back-to-back frame, R=G=B=c+8r.
    clear_counts();
    send_frame(0, 0, ROWS * COLS, 1'b1);
    drain();
    check_val("first3", first3, 72'h000102_08090a_101112);
    check_val("count3", wcnt3, 24);
    check_val("last3", {last_r3[7:0], last_c3[7:0]}, 16'h0406);
    check_val("count5", wcnt5, 8);
    check_val("first5", {first_r5[7:0], first_c5[7:0]}, 16'h0202);
    check_val("last5", {last_r5[7:0], last_c5[7:0]}, 16'h0305);

    // Frame finished: further pixels without a frame start are ignored.
    clear_counts();
    send_frame(9, 0, 6, 1'b0);
    drain();
    check_val("done_ignore", wcnt3 + wcnt5, 0);

    // Same frame with random 0-5 cycle gaps.
    clear_counts();
    send_frame(0, 5, ROWS * COLS, 1'b1);
    drain();
    check_val("gap_first3", first3, 72'h000102_08090a_101112);
    check_val("gap_count3", wcnt3, 24);
    check_val("gap_count5", wcnt5, 8);
    check_val("gap_last3", {last_r3[7:0], last_c3[7:0]}, 16'h0406);

    // Frame start at pixel (3,4) restarts with a new frame.
    clear_counts();
    send_frame(100, 0, 3 * COLS + 4, 1'b1);
    send_frame(50, 0, ROWS * COLS, 1'b1);
    drain();
    check_val("restart_count3", wcnt3, 32);
    check_val("restart_count5", wcnt5, 8);

    // Reset in row 3 drops in-flight windows; remaining pixels are ignored.
    send_frame(7, 0, 3 * COLS + 2, 1'b1);
    @(negedge clk);
    rst = 1'b1; pv = 1'b1; pf = 1'b0;
    q3.delete(); q5.delete(); m_active = 1'b0; m_row = 0; m_col = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0; pv = 1'b0;
    clear_counts();
    send_frame(7 + 3 * COLS + 2, 0, ROWS * COLS - (3 * COLS + 2), 1'b0);
    drain();
    check_val("post_reset_wins", wcnt3 + wcnt5, 0);

    // Pure red frame exercises the grayscale weights.
    clear_counts();
    send_const(24'hff0000);
    drain();
`ifdef BUFFERED_MATRIXN_BT601_EN
    red_g = 8'd76;
`else
    red_g = 8'd63;
`endif
    red_win = {9{red_g}};
    check_val("red3", first3, red_win);
    check_val("red_count3", wcnt3, 24);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
